// File: rtl/qam_tx_front.sv
// qam_tx_front: serial-bit to I/Q sample front end for the baseband transmitter.
//
// Takes a serial bit stream and assembles 2-bit (QPSK) or 4-bit (16-QAM)
// symbols. Each symbol is Gray-mapped to signed I/Q levels and queued in a
// small symbol FIFO. An output stage then emits OSR samples per symbol,
// either zero-inserted or sample-held.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   flush      synchronous clear of partial symbol, FIFO, output stage, underrun
//   en         bit valid
//   Bin        serial data bit, MSB of the symbol first
//   mode       0 = QPSK, 1 = 16-QAM (sampled at the first bit of a symbol)
//   bit_ready  a bit is taken on any edge with en && bit_ready
//   I_out      signed in-phase sample (registered)
//   Q_out      signed quadrature sample (registered)
//   out_valid  I_out/Q_out carry a symbol phase
//   sym_start  high on phase 0 of each symbol
//   underrun   sticky: output ran dry while a symbol was half assembled
module qam_tx_front #(
    parameter int OSR        = 4,
    parameter int LVL_W      = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int UPMODE     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    en,
    input  logic                    Bin,
    input  logic                    mode,
    output logic                    bit_ready,
    output logic signed [LVL_W-1:0] I_out,
    output logic signed [LVL_W-1:0] Q_out,
    output logic                    out_valid,
    output logic                    sym_start,
    output logic                    underrun
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PHW = $clog2(OSR);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    // Gray-coded 16-QAM axis level: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3
    function automatic logic signed [LVL_W-1:0] qam_lvl(input logic [1:0] b);
        logic signed [LVL_W-1:0] v;
        case (b)
            2'b00:   v = LVL_W'(-3);
            2'b01:   v = LVL_W'(-1);
            2'b11:   v = LVL_W'(1);
            default: v = LVL_W'(3);
        endcase
        return v;
    endfunction

    function automatic logic signed [LVL_W-1:0] qpsk_lvl(input logic b);
        return b ? LVL_W'(-1) : LVL_W'(1);
    endfunction

    // ---------------- S/P stage ----------------
    logic [1:0] cnt;
    logic [2:0] sreg;
    logic       sym_mode;

    logic       fifo_full, fifo_empty;
    logic       accept, last_bit, push, pop;
    logic       eff_mode;
    logic [3:0] bits_n;
    logic signed [LVL_W-1:0] map_i, map_q;

    // The first bit of a symbol uses the live mode input; later bits use the latched one.
    assign eff_mode = (cnt == 2'd0) ? mode : sym_mode;
    assign accept   = en && bit_ready;
    assign last_bit = eff_mode ? (cnt == 2'd3) : (cnt == 2'd1);
    assign push     = accept && last_bit;
    assign bits_n   = {sreg, Bin};

    always_comb begin
        map_i = '0;
        map_q = '0;
        if (eff_mode) begin
            map_i = qam_lvl(bits_n[3:2]);
            map_q = qam_lvl(bits_n[1:0]);
        end else begin
            map_i = qpsk_lvl(bits_n[1]);
            map_q = qpsk_lvl(bits_n[0]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            sreg     <= '0;
            sym_mode <= 1'b0;
        end else if (flush) begin
            cnt      <= '0;
            sreg     <= '0;
            sym_mode <= 1'b0;
        end else if (accept) begin
            sreg <= {sreg[1:0], Bin};
            if (cnt == 2'd0) sym_mode <= mode;
            cnt <= last_bit ? 2'd0 : cnt + 2'd1;
        end
    end

    // ---------------- symbol FIFO ----------------
    logic [FIFO_DEPTH-1:0][2*LVL_W-1:0] mem;
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic signed [LVL_W-1:0] head_i, head_q;

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign {head_i, head_q} = mem[rp];

    // Reset is an input, so bit_ready drops the moment reset asserts.
    assign bit_ready = reset && !fifo_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem   <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            mem   <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= {map_i, map_q};
                wp      <= ptr_inc(wp);
            end
            if (pop) rp <= ptr_inc(rp);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- output stage ----------------
    logic [0:0]     state;
    logic [PHW-1:0] phase;
    logic signed [LVL_W-1:0] sym_i, sym_q;
    logic           last_ph;

    assign last_ph = (phase == PHW'(OSR - 1));
    assign pop     = !fifo_empty && ((state == S_IDLE) || last_ph);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            phase     <= '0;
            sym_i     <= '0;
            sym_q     <= '0;
            I_out     <= '0;
            Q_out     <= '0;
            out_valid <= 1'b0;
            sym_start <= 1'b0;
            underrun  <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            phase     <= '0;
            sym_i     <= '0;
            sym_q     <= '0;
            I_out     <= '0;
            Q_out     <= '0;
            out_valid <= 1'b0;
            sym_start <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            // Output ran dry while bits of the next symbol are still arriving.
            if (state == S_ACTIVE && last_ph && fifo_empty && cnt != 2'd0)
                underrun <= 1'b1;

            if (pop) begin
                state     <= S_ACTIVE;
                phase     <= '0;
                sym_i     <= head_i;
                sym_q     <= head_q;
                I_out     <= head_i;
                Q_out     <= head_q;
                out_valid <= 1'b1;
                sym_start <= 1'b1;
            end else if (state == S_ACTIVE && !last_ph) begin
                phase     <= phase + PHW'(1);
                I_out     <= (UPMODE != 0) ? sym_i : '0;
                Q_out     <= (UPMODE != 0) ? sym_q : '0;
                out_valid <= 1'b1;
                sym_start <= 1'b0;
            end else begin
                state     <= S_IDLE;
                phase     <= '0;
                I_out     <= '0;
                Q_out     <= '0;
                out_valid <= 1'b0;
                sym_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qam_tx_front.sv
// tb_qam_tx_front: directed bench for qam_tx_front. Two instances share the
// stimulus: one zero-insert, one sample-hold. A queue-based symbol model
// predicts every output on every cycle. Literal checks pin the model.
module tb_qam_tx_front;
    localparam int OSR   = 4;
    localparam int LVL_W = 4;
    localparam int DEPTH = 2;

    logic clk = 1'b0, reset = 1'b0, flush = 1'b0, en = 1'b0, Bin = 1'b0, mode = 1'b0;
    logic rdy0, rdy1, v0, v1, s0, s1, u0, u1;
    logic signed [LVL_W-1:0] i0, q0, i1, q1;

    always #5 clk = ~clk;

    qam_tx_front #(.OSR(OSR), .LVL_W(LVL_W), .FIFO_DEPTH(DEPTH), .UPMODE(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .en(en), .Bin(Bin), .mode(mode),
        .bit_ready(rdy0), .I_out(i0), .Q_out(q0), .out_valid(v0), .sym_start(s0),
        .underrun(u0));

    qam_tx_front #(.OSR(OSR), .LVL_W(LVL_W), .FIFO_DEPTH(DEPTH), .UPMODE(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .en(en), .Bin(Bin), .mode(mode),
        .bit_ready(rdy1), .I_out(i1), .Q_out(q1), .out_valid(v1), .sym_start(s1),
        .underrun(u1));

    int vectors = 0, miscompares = 0;

    task automatic chk(input string name, input integer act, input integer exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  mq_i[$], mq_q[$];     // queued symbols
    int  mbits[$];             // bits of the symbol being assembled
    bit  m_mode, m_rst_n;
    bit  m_busy;
    int  m_left;               // samples still to emit after the current one
    int  m_ci, m_cq;
    int  e_i0, e_q0, e_i1, e_q1;
    bit  e_v, e_s, e_u;
    int  gray[4] = '{-3, -1, 3, 1};

    task automatic model_clear();
        mq_i.delete(); mq_q.delete(); mbits.delete();
        m_mode = 0; m_busy = 0; m_left = 0; m_ci = 0; m_cq = 0;
        e_i0 = 0; e_q0 = 0; e_i1 = 0; e_q1 = 0; e_v = 0; e_s = 0; e_u = 0;
    endtask

    task automatic model_step(input bit e, input bit b, input bit md, input bit fl);
        bit acc;
        int need;
        if (fl) begin
            model_clear();
            return;
        end
        acc = e && (mq_i.size() < DEPTH);
        if (m_busy && m_left == 0 && mq_i.size() == 0 && mbits.size() != 0) e_u = 1;
        if (mq_i.size() > 0 && (!m_busy || m_left == 0)) begin
            m_ci = mq_i.pop_front(); m_cq = mq_q.pop_front();
            m_busy = 1; m_left = OSR - 1;
            e_i0 = m_ci; e_q0 = m_cq; e_i1 = m_ci; e_q1 = m_cq; e_v = 1; e_s = 1;
        end else if (m_busy && m_left > 0) begin
            m_left--;
            e_i0 = 0; e_q0 = 0; e_i1 = m_ci; e_q1 = m_cq; e_v = 1; e_s = 0;
        end else begin
            m_busy = 0;
            e_i0 = 0; e_q0 = 0; e_i1 = 0; e_q1 = 0; e_v = 0; e_s = 0;
        end
        if (acc) begin
            if (mbits.size() == 0) m_mode = md;
            mbits.push_back(b);
            need = m_mode ? 4 : 2;
            if (mbits.size() == need) begin
                if (!m_mode) begin
                    mq_i.push_back(mbits[0] ? -1 : 1);
                    mq_q.push_back(mbits[1] ? -1 : 1);
                end else begin
                    mq_i.push_back(gray[mbits[0]*2 + mbits[1]]);
                    mq_q.push_back(gray[mbits[2]*2 + mbits[3]]);
                end
                mbits.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("bit_ready", rdy0, (m_rst_n && mq_i.size() < DEPTH) ? 1 : 0);
        chk("I_zi", $signed(i0), e_i0);
        chk("Q_zi", $signed(q0), e_q0);
        chk("I_hold", $signed(i1), e_i1);
        chk("Q_hold", $signed(q1), e_q1);
        chk("out_valid", v0, e_v);
        chk("out_valid_hold", v1, e_v);
        chk("sym_start", s0, e_s);
        chk("underrun", u0, e_u);
    endtask

    task automatic tick(input bit e, input bit b, input bit md, input bit fl);
        en = e; Bin = b; mode = md; flush = fl;
        @(posedge clk);
        model_step(e, b, md, fl);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0, 0);
    endtask

    int lows;
    bit qam_bits[8] = '{1, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        model_clear();
        m_rst_n = 0;

        // reset state
        #2; check_all();
        @(posedge clk); #1; check_all();
        reset = 1'b1; m_rst_n = 1;
        #1; check_all();
        chk("ready_after_reset", rdy0, 1);

        // QPSK 0,1 -> (+1,-1) two edges after the last bit
        tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        tick(0, 0, 0, 0);
        chk("qpsk01_I", $signed(i0), 1);
        chk("qpsk01_Q", $signed(q0), -1);
        chk("qpsk01_start", s0, 1);
        idle(3);
        chk("qpsk01_zero_ph3", $signed(i0), 0);
        chk("qpsk01_valid_ph3", v0, 1);
        tick(0, 0, 0, 0);
        chk("qpsk01_done", v0, 0);
        idle(2);

        // 16-QAM back-to-back: (+3,-1) then (+1,+1)
        for (int k = 0; k < 14; k++) begin
            if (k < 8) tick(1, qam_bits[k], 1, 0);
            else tick(0, 0, 1, 0);
            if (k == 4) begin
                chk("qam_s1_I", $signed(i0), 3);
                chk("qam_s1_Q", $signed(q0), -1);
            end
            if (k == 8) begin
                chk("qam_s2_I", $signed(i0), 1);
                chk("qam_s2_Q", $signed(q0), 1);
                chk("qam_s2_start", s0, 1);
            end
        end

        // sample-hold QPSK 1,1 -> (-1,-1) on all four phases
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 0, 0);
            chk("hold_I", $signed(i1), -1);
            chk("hold_Q", $signed(q1), -1);
        end
        tick(0, 0, 0, 0);
        chk("hold_done", v1, 0);

        // continuous QPSK: FIFO fills, bit_ready throttles, stream stays gapless
        lows = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1, ((k * 7) % 5) > 1, 0, 0);
            if (!rdy0) lows++;
        end
        chk("ready_dropped", (lows > 0) ? 1 : 0, 1);
        idle(12);
        tick(0, 0, 0, 1);

        // mode toggled after first bit: QPSK (-1,+1), then 16-QAM 0010 -> (-3,+3)
        tick(1, 1, 0, 0);
        tick(1, 0, 1, 0);
        tick(1, 0, 1, 0);
        chk("toggle_I", $signed(i0), -1);
        chk("toggle_Q", $signed(q0), 1);
        tick(1, 0, 1, 0);
        tick(1, 1, 1, 0);
        tick(1, 0, 1, 0);
        tick(0, 0, 0, 0);
        chk("toggle_qam_I", $signed(i0), -3);
        chk("toggle_qam_Q", $signed(q0), 3);
        idle(6);

        // underrun: one symbol out, three bits of 16-QAM pending
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 0);
        tick(1, 1, 1, 0);
        tick(1, 1, 1, 0);
        idle(4);
        chk("underrun_set", u0, 1);
        idle(2);
        chk("underrun_sticky", u0, 1);
        tick(0, 0, 0, 1);
        chk("flush_underrun", u0, 0);
        chk("flush_valid", v0, 0);
        tick(1, 1, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("post_flush_I", $signed(i0), -1);
        chk("post_flush_Q", $signed(q0), 1);
        idle(5);

        // async reset at phase 2 of a symbol
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("pre_reset_valid", v0, 1);
        #2; reset = 1'b0;
        #1;
        model_clear(); m_rst_n = 0;
        check_all();
        chk("async_reset_I", $signed(i0), 0);
        @(posedge clk); #1; check_all();
        reset = 1'b1; m_rst_n = 1;
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        tick(0, 0, 0, 0);
        chk("post_reset_I", $signed(i0), -1);
        chk("post_reset_Q", $signed(q0), -1);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
